// File: rtl/b20_enum_seq_if.sv
// Keystream-bit intake and candidate output stream of the b20 enumerator sequencer.
interface b20_enum_seq_if;
    logic        BIT_VALID;
    logic        BIT_IN;
    logic        BIT_READY;
    logic        CAND_VALID;
    logic        CAND_READY;
    logic [19:0] CAND_KEY20;
    logic [14:0] CAND_NUM;
    logic        CAND_LAST;
    logic [3:0]  CAND_FC_IDX;

    modport master (
        output BIT_VALID, BIT_IN, CAND_READY,
        input  BIT_READY, CAND_VALID, CAND_KEY20, CAND_NUM, CAND_LAST, CAND_FC_IDX
    );

    modport slave (
        input  BIT_VALID, BIT_IN, CAND_READY,
        output BIT_READY, CAND_VALID, CAND_KEY20, CAND_NUM, CAND_LAST, CAND_FC_IDX
    );
endinterface

// File: rtl/b20_enum_seq.sv
// Sequences one 20-bit Fc-index enumerator per keystream bit and streams its 32768 candidates.
// Defining B20_ENUM_SEQ_PERF_EN adds STALL_CNT, a saturating count of downstream stall cycles.
module b20_enum_seq #(
    parameter logic [3:0] IDX = 4'd0
) (
    input  logic          CLK,
    input  logic          RESET,
    b20_enum_seq_if.slave io,
    input  logic          ABORT,
    output logic          ENUM_RSTn,
    output logic          ENUM_STB,
    output logic          ENUM_BIT,
    input  logic [19:0]   ENUM_KEY20,
    output logic          DONE
`ifdef B20_ENUM_SEQ_PERF_EN
    ,
    output logic [31:0]   STALL_CNT
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic        ebit_q, ebit_d;
    logic        vld_q, vld_d;
    logic [19:0] key_q, key_d;
    logic [14:0] num_q, num_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        bit_hs, load, acc, abort_job;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ebit_d    = ebit_q;
        vld_d     = vld_q;
        key_d     = key_q;
        num_d     = num_q;
        last_d    = last_q;
        done_d    = 1'b0;
        bit_hs    = 1'b0;
        load      = 1'b0;
        acc       = vld_q & io.CAND_READY;
        abort_job = ABORT & (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (io.BIT_VALID) begin
                    bit_hs  = 1'b1;
                    ebit_d  = io.BIT_IN;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // The output register refills whenever it is empty or being drained this cycle.
                load = !vld_q | io.CAND_READY;
                if (load) begin
                    key_d  = ENUM_KEY20;
                    num_d  = cnt_q;
                    last_d = (cnt_q == 15'h7FFF);
                    vld_d  = 1'b1;
                    cnt_d  = cnt_q + 15'd1;
                    if (cnt_q == 15'h7FFF) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (acc) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_job) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ebit_q  <= 1'b0;
            vld_q   <= 1'b0;
            key_q   <= '0;
            num_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ebit_q  <= ebit_d;
            vld_q   <= vld_d;
            key_q   <= key_d;
            num_q   <= num_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign io.BIT_READY   = (state_q == S_IDLE);
    assign io.CAND_VALID  = vld_q;
    assign io.CAND_KEY20  = key_q;
    assign io.CAND_NUM    = num_q;
    assign io.CAND_LAST   = last_q;
    assign io.CAND_FC_IDX = IDX;
    assign ENUM_RSTn      = !RESET & (state_q != S_CLEAR);
    assign ENUM_STB       = load;
    assign ENUM_BIT       = ebit_q;
    assign DONE           = done_q;

`ifdef B20_ENUM_SEQ_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RESET || bit_hs) begin
            stall_q <= '0;
        end else if (vld_q && !io.CAND_READY && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_q;
`endif
endmodule

// File: tb/tb_b20_enum_seq.sv
// Bench for b20_enum_seq: per-cycle vector table, scoreboarded candidate stream, hand-written corner sequences.
module tb_b20_enum_seq;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ABORT = 1'b0;
    logic        ENUM_RSTn, ENUM_STB, ENUM_BIT, DONE;
    logic [19:0] ENUM_KEY20;
`ifdef B20_ENUM_SEQ_PERF_EN
    logic [31:0] STALL_CNT;
`endif
    int total = 0;
    int bad = 0;
    int cyc = 0;

    b20_enum_seq_if bus();

    b20_enum_seq #(.IDX(4'd9)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .io         (bus),
        .ABORT      (ABORT),
        .ENUM_RSTn  (ENUM_RSTn),
        .ENUM_STB   (ENUM_STB),
        .ENUM_BIT   (ENUM_BIT),
        .ENUM_KEY20 (ENUM_KEY20),
        .DONE       (DONE)
`ifdef B20_ENUM_SEQ_PERF_EN
        ,
        .STALL_CNT  (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Candidate k of a job with keystream bit b, as produced by the attached enumerator.
    function automatic logic [19:0] cand_of(input int idx, input logic b);
        logic [19:0] k;
        k = 20'(idx * 40503);
        return k ^ (b ? 20'hA5A5A : 20'h0F0F0);
    endfunction

    logic [14:0] ecnt;
    always @(posedge CLK) begin
        if (!ENUM_RSTn) ecnt <= '0;
        else if (ENUM_STB) ecnt <= ecnt + 15'd1;
    end
    assign ENUM_KEY20 = cand_of(int'(ecnt), ENUM_BIT);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted candidate must be the next index of the current job.
    int          exp_idx = 0;
    logic        job_bit = 1'b0;
    logic        hold_vld = 1'b0;
    logic [35:0] hold_dat;
    always @(negedge CLK) begin
        #2;
        cyc++;
        if (RESET) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && bus.CAND_VALID)
                chk("stall_hold", {bus.CAND_LAST, bus.CAND_NUM, bus.CAND_KEY20}, hold_dat);
            hold_vld = bus.CAND_VALID && !bus.CAND_READY;
            hold_dat = {bus.CAND_LAST, bus.CAND_NUM, bus.CAND_KEY20};
            if (hold_vld) chk("stb_in_stall", ENUM_STB, 0);
            if (bus.CAND_VALID && bus.CAND_READY) begin
                chk("cand_num", bus.CAND_NUM, exp_idx);
                chk("cand_key", bus.CAND_KEY20, cand_of(exp_idx, job_bit));
                chk("cand_last", bus.CAND_LAST, (exp_idx == 32767));
                exp_idx++;
            end
            if (DONE) chk("done_count", exp_idx, 32768);
            if (bus.BIT_VALID && bus.BIT_READY) begin
                exp_idx = 0;
                job_bit = bus.BIT_IN;
            end
        end
    end

    typedef struct {
        logic ab, bv, bi, rdy;
        logic e_brdy, e_cv, e_rstn, e_stb, e_ebit;
        logic [14:0] e_num;
    } vec_t;
    vec_t tbl[12];

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_brdy"}, bus.BIT_READY, 1);
        chk({tag, "_rstn"}, ENUM_RSTn, 0);
        chk({tag, "_stb"}, ENUM_STB, 0);
        chk({tag, "_ebit"}, ENUM_BIT, 0);
        chk({tag, "_cv"}, bus.CAND_VALID, 0);
        chk({tag, "_key"}, bus.CAND_KEY20, 0);
        chk({tag, "_num"}, bus.CAND_NUM, 0);
        chk({tag, "_last"}, bus.CAND_LAST, 0);
        chk({tag, "_done"}, DONE, 0);
`ifdef B20_ENUM_SEQ_PERF_EN
        chk({tag, "_stall"}, STALL_CNT, 0);
`endif
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            #3;
            if (DONE) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int  t0, td;
        bit  found;

        //            ab bv bi rdy | brdy cv rstn stb ebit num
        tbl[0]  = '{0, 0, 0, 0,     1, 0, 1, 0, 0, 15'd0};
        tbl[1]  = '{0, 1, 1, 0,     1, 0, 1, 0, 0, 15'd0};
        tbl[2]  = '{0, 0, 0, 0,     0, 0, 0, 0, 1, 15'd0};
        tbl[3]  = '{0, 0, 0, 0,     0, 0, 1, 1, 1, 15'd0};
        tbl[4]  = '{0, 0, 0, 0,     0, 1, 1, 0, 1, 15'd0};
        tbl[5]  = '{0, 0, 0, 1,     0, 1, 1, 1, 1, 15'd0};
        tbl[6]  = '{0, 0, 0, 1,     0, 1, 1, 1, 1, 15'd1};
        tbl[7]  = '{1, 0, 0, 0,     0, 1, 1, 0, 1, 15'd2};
        tbl[8]  = '{0, 0, 0, 0,     1, 0, 1, 0, 1, 15'd0};
        tbl[9]  = '{1, 1, 0, 0,     1, 0, 1, 0, 1, 15'd0};
        tbl[10] = '{1, 0, 0, 0,     0, 0, 0, 0, 0, 15'd0};
        tbl[11] = '{0, 0, 0, 0,     1, 0, 1, 0, 0, 15'd0};

        bus.BIT_VALID  = 1'b0;
        bus.BIT_IN     = 1'b0;
        bus.CAND_READY = 1'b0;
        repeat (3) @(negedge CLK);
        #3;
        chk_reset_vals("por");
        chk("fc_idx", bus.CAND_FC_IDX, 9);

        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            RESET = 1'b0;
            ABORT = tbl[i].ab;
            bus.BIT_VALID = tbl[i].bv;
            bus.BIT_IN = tbl[i].bi;
            bus.CAND_READY = tbl[i].rdy;
            #3;
            chk($sformatf("v%0d_brdy", i), bus.BIT_READY, tbl[i].e_brdy);
            chk($sformatf("v%0d_cv", i), bus.CAND_VALID, tbl[i].e_cv);
            chk($sformatf("v%0d_rstn", i), ENUM_RSTn, tbl[i].e_rstn);
            chk($sformatf("v%0d_stb", i), ENUM_STB, tbl[i].e_stb);
            chk($sformatf("v%0d_ebit", i), ENUM_BIT, tbl[i].e_ebit);
            chk($sformatf("v%0d_done", i), DONE, 0);
            if (tbl[i].e_cv) chk($sformatf("v%0d_num", i), bus.CAND_NUM, tbl[i].e_num);
        end

        // Full job, bit 0, no backpressure; next bit held for back-to-back start.
        @(negedge CLK);
        ABORT = 1'b0;
        bus.BIT_VALID = 1'b1;
        bus.BIT_IN = 1'b0;
        bus.CAND_READY = 1'b1;
        #3;
        t0 = cyc;
        @(negedge CLK);
        bus.BIT_IN = 1'b1;
        wait_done(33000, td);
        chk("done_seen", (td >= 0), 1);
        chk("job_len", td - t0, 32771);
        chk("done_brdy", bus.BIT_READY, 1);
        @(negedge CLK);
        bus.BIT_VALID = 1'b0;
        #3;
        chk("done_pulse", DONE, 0);
        chk("b2b_clear", ENUM_RSTn, 0);
        @(negedge CLK);
        #3;
        chk("b2b_v2", bus.CAND_VALID, 0);
        @(negedge CLK);
        #3;
        chk("b2b_v3", bus.CAND_VALID, 1);
        chk("b2b_num", bus.CAND_NUM, 0);
        chk("b2b_ebit", ENUM_BIT, 1);

        // Hold index 5 for ten cycles.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (bus.CAND_VALID && bus.CAND_NUM == 15'd5) begin
                bus.CAND_READY = 1'b0;
                found = 1;
            end
        end
        chk("stall_found", found, 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            #3;
            chk("stall_stb", ENUM_STB, 0);
            chk("stall_num", bus.CAND_NUM, 5);
        end
        @(negedge CLK);
        bus.CAND_READY = 1'b1;
        #3;
`ifdef B20_ENUM_SEQ_PERF_EN
        chk("stall_cnt", STALL_CNT, 10);
`endif
        @(negedge CLK);
        #3;
        chk("resume_num", bus.CAND_NUM, 6);

        // Random backpressure until index 1000, then abort.
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge CLK);
            bus.CAND_READY = 1'($urandom_range(0, 1));
            if (bus.CAND_VALID && bus.CAND_NUM == 15'd1000) begin
                ABORT = 1'b1;
                found = 1;
            end
        end
        chk("abort_found", found, 1);
        @(negedge CLK);
        ABORT = 1'b0;
        bus.CAND_READY = 1'b1;
        #3;
        chk("abort_cv", bus.CAND_VALID, 0);
        chk("abort_done", DONE, 0);
        chk("abort_brdy", bus.BIT_READY, 1);
        chk("abort_stb", ENUM_STB, 0);

        // Restart with bit 1 and run into the drain state under backpressure.
        @(negedge CLK);
        bus.BIT_VALID = 1'b1;
        bus.BIT_IN = 1'b1;
        #3;
        chk("restart_done", DONE, 0);
        @(negedge CLK);
        bus.BIT_VALID = 1'b0;
        #3;
        chk("restart_rstn0", ENUM_RSTn, 0);
        @(negedge CLK);
        #3;
        chk("restart_rstn1", ENUM_RSTn, 1);
        @(negedge CLK);
        #3;
        chk("restart_cv", bus.CAND_VALID, 1);
        chk("restart_num", bus.CAND_NUM, 0);
        found = 0;
        for (int i = 0; i < 33000 && !found; i++) begin
            @(negedge CLK);
            if (bus.CAND_VALID && bus.CAND_NUM == 15'h7FFF) begin
                bus.CAND_READY = 1'b0;
                found = 1;
            end
        end
        chk("drain_found", found, 1);
        #3;
        chk("drain_last", bus.CAND_LAST, 1);
        chk("drain_stb", ENUM_STB, 0);
        @(negedge CLK);
        RESET = 1'b1;
        #3;
        chk("rst_rstn", ENUM_RSTn, 0);
        @(negedge CLK);
        #3;
        chk_reset_vals("mid");
        @(negedge CLK);
        RESET = 1'b0;
        bus.CAND_READY = 1'b1;
        #3;
        chk("post_rst_done", DONE, 0);
        chk("post_rst_rstn", ENUM_RSTn, 1);
        @(negedge CLK);
        #3;
        chk("post_rst_done2", DONE, 0);
        chk("post_rst_cv", bus.CAND_VALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
